regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: requester 0 is ALU writeback, requester 1 is load/memory writeback. The block does round-robin arbitration with a bounded burst length. It registers the winning write onto the register file write port, drops writes to the zero register (XZR), and keeps per-requester stall statistics. It sits between the execute/memory writeback stages and the register file.

---
 rtl/regfile_write_arbiter_pkg.sv | 22 ++
 rtl/regfile_write_arbiter_rr_arb2_burst.sv | 67 ++++++
 rtl/regfile_write_arbiter.sv | 97 +++++++++
 tb/tb_regfile_write_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter_pkg : shared constants and requester encoding
// Rev 1.0
// ============================================================================
package regfile_write_arbiter_pkg;

   localparam int DATA_WIDTH_DEF = 64;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int ZERO_REG_DEF   = 31;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_idx_e;

   function automatic req_idx_e other_req(input req_idx_e idx);
      return (idx == REQ_ALU) ? REQ_MEM : REQ_ALU;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arb2_burst.sv
`default_nettype none
// ============================================================================
// rr_arb2_burst : two-way round-robin grant with bounded burst length
// Rev 1.0
// ============================================================================
module rr_arb2_burst
   import regfile_write_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic freeze,
   input  logic valid0,
   input  logic valid1,
   output logic ready0,
   output logic ready1,
   output logic last_grant
);

   localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

   req_idx_e         last_q, last_d, winner;
   logic [CNT_W-1:0] burst_q, burst_d;
   logic             contested, keep, any_grant;

   always_comb begin
      contested = valid0 && valid1;
      // A zero count means no run is in progress, so the other side goes first.
      keep      = (burst_q != '0) && (burst_q < MAX_B);
      if (contested)
         winner = keep ? last_q : other_req(last_q);
      else if (valid1)
         winner = REQ_MEM;
      else
         winner = REQ_ALU;

      any_grant = !reset && !freeze && (valid0 || valid1);
      ready0    = any_grant && (winner == REQ_ALU);
      ready1    = any_grant && (winner == REQ_MEM);

      last_d  = last_q;
      burst_d = burst_q;
      if (any_grant) begin
         last_d = winner;
         if (contested && (winner == last_q))
            burst_d = burst_q + 1'b1;
         else
            burst_d = CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q  <= REQ_MEM;
         burst_q <= '0;
      end else begin
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   assign last_grant = last_q;

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter : shares the register file write port between ALU and
// memory writeback, filters XZR writes and keeps saturating stall counters.
// Rev 1.0
// ============================================================================
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int ZERO_REG   = ZERO_REG_DEF,
   parameter int MAX_BURST  = 4,
   parameter int STALL_W    = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  freeze,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  rf_reg_write,
   output logic [ADDR_WIDTH-1:0] rf_write_register,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic                  last_grant,
   output logic [STALL_W-1:0]    stall0_count,
   output logic [STALL_W-1:0]    stall1_count
);

   localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(ZERO_REG);

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, sel_addr;
   logic [DATA_WIDTH-1:0] data_q, data_d, sel_data;
   logic [STALL_W-1:0]    stall0_q, stall0_d, stall1_q, stall1_d;
   logic                  accept;

   rr_arb2_burst #(
      .MAX_BURST (MAX_BURST)
   ) u_arb (
      .clock      (clock),
      .reset      (reset),
      .freeze     (freeze),
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .ready0     (req0_ready),
      .ready1     (req1_ready),
      .last_grant (last_grant)
   );

   always_comb begin
      accept   = req0_ready || req1_ready;
      sel_addr = req1_ready ? req1_addr : req0_addr;
      sel_data = req1_ready ? req1_data : req0_data;

      we_d   = accept && (sel_addr != XZR);
      addr_d = we_d ? sel_addr : addr_q;
      data_d = we_d ? sel_data : data_q;

      stall0_d = stall0_q;
      if (req0_valid && !req0_ready && (stall0_q != '1))
         stall0_d = stall0_q + 1'b1;
      stall1_d = stall1_q;
      if (req1_valid && !req1_ready && (stall1_q != '1))
         stall1_d = stall1_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         stall0_q <= '0;
         stall1_q <= '0;
      end else begin
         we_q     <= we_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         stall0_q <= stall0_d;
         stall1_q <= stall1_d;
      end
   end

   // A write captured just before reset must not reach the register file.
   assign rf_reg_write      = we_q && !reset;
   assign rf_write_register = addr_q;
   assign rf_write_data     = data_q;
   assign stall0_count      = stall0_q;
   assign stall1_count      = stall1_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_write_arbiter : directed + random checks against a reference model
// Rev 1.0
// ============================================================================
module tb_regfile_write_arbiter;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int ZR = 31;
   localparam int MB = 4;
   localparam int SW = 8;
   localparam int SAT = (1 << SW) - 1;

   logic          clock = 1'b0;
   logic          reset, freeze;
   logic          req0_valid, req1_valid, req0_ready, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr, rf_write_register;
   logic [DW-1:0] req0_data, req1_data, rf_write_data;
   logic          rf_reg_write, last_grant;
   logic [SW-1:0] stall0_count, stall1_count;

   int total = 0;
   int bad   = 0;

   // reference model state
   int            m_last, m_run, m_st0, m_st1;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   bit            g0, g1;
   logic          r0_obs, r1_obs;

   always #5 clock = ~clock;

   regfile_write_arbiter #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ZERO_REG (ZR),
      .MAX_BURST (MB), .STALL_W (SW)
   ) dut (
      .clock (clock), .reset (reset), .freeze (freeze),
      .req0_valid (req0_valid), .req0_addr (req0_addr), .req0_data (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid), .req1_addr (req1_addr), .req1_data (req1_data),
      .req1_ready (req1_ready),
      .rf_reg_write (rf_reg_write), .rf_write_register (rf_write_register),
      .rf_write_data (rf_write_data), .last_grant (last_grant),
      .stall0_count (stall0_count), .stall1_count (stall1_count)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Grant rules: lone requester always wins; under contention the previous
   // owner keeps the port only while its run is active and below MB.
   task automatic model_grant();
      g0 = 0; g1 = 0;
      if (!reset && !freeze) begin
         if (req0_valid && req1_valid) begin
            if (m_run > 0 && m_run < MB) begin
               g0 = (m_last == 0); g1 = (m_last == 1);
            end else begin
               g0 = (m_last == 1); g1 = (m_last == 0);
            end
         end else begin
            g0 = req0_valid; g1 = req1_valid;
         end
      end
   endtask

   task automatic model_clock();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int w;
      if (reset) begin
         m_we = 0; m_addr = '0; m_data = '0;
         m_last = 1; m_run = 0; m_st0 = 0; m_st1 = 0;
      end else begin
         if (req0_valid && !g0) m_st0 = (m_st0 < SAT) ? m_st0 + 1 : SAT;
         if (req1_valid && !g1) m_st1 = (m_st1 < SAT) ? m_st1 + 1 : SAT;
         m_we = 0;
         if (g0 || g1) begin
            a = g1 ? req1_addr : req0_addr;
            d = g1 ? req1_data : req0_data;
            if (a != AW'(ZR)) begin
               m_we = 1; m_addr = a; m_data = d;
            end
            w = g1 ? 1 : 0;
            if (req0_valid && req1_valid && w == m_last) m_run = m_run + 1;
            else m_run = 1;
            m_last = w;
         end
      end
   endtask

   // Called at a negedge with inputs already applied.
   task automatic step();
      #1;
      model_grant();
      r0_obs = req0_ready;
      r1_obs = req1_ready;
      chk("ready0", req0_ready, g0);
      chk("ready1", req1_ready, g1);
      chk("rf_we_pre", rf_reg_write, m_we && !reset);
      @(posedge clock);
      model_clock();
      @(negedge clock);
      chk("rf_we", rf_reg_write, m_we && !reset);
      chk("rf_addr", rf_write_register, m_addr);
      chk("rf_data", rf_write_data, m_data);
      chk("last_grant", last_grant, m_last[0]);
      chk("stall0", stall0_count, m_st0[SW-1:0]);
      chk("stall1", stall1_count, m_st1[SW-1:0]);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return ($urandom_range(0, 7) == 0) ? AW'(ZR) : AW'($urandom_range(0, 31));
   endfunction

   task automatic do_reset();
      reset = 1; req0_valid = 0; req1_valid = 0; freeze = 0;
      step(); step();
      reset = 0;
   endtask

   initial begin
      reset = 1; freeze = 0;
      req0_valid = 0; req1_valid = 0;
      req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
      m_we = 0; m_addr = '0; m_data = '0; m_last = 1; m_run = 0; m_st0 = 0; m_st1 = 0;
      @(negedge clock);
      do_reset();
      chk("rst_we", rf_reg_write, 1'b0);
      chk("rst_addr", rf_write_register, '0);
      chk("rst_last", last_grant, 1'b1);
      chk("rst_st0", stall0_count, '0);

      // single write X3
      req0_valid = 1; req0_addr = 5'd3; req0_data = 64'h1234;
      step();
      chk("x3_ready", r0_obs, 1'b1);
      chk("x3_we", rf_reg_write, 1'b1);
      chk("x3_addr", rf_write_register, 5'd3);
      chk("x3_data", rf_write_data, 64'h1234);

      // XZR write from requester 1
      req0_valid = 0; req1_valid = 1; req1_addr = 5'd31; req1_data = 64'hFFFF;
      step();
      chk("xzr_ready", r1_obs, 1'b1);
      chk("xzr_we", rf_reg_write, 1'b0);
      chk("xzr_last", last_grant, 1'b1);

      // contested bursts
      do_reset();
      req0_valid = 1; req1_valid = 1;
      req0_addr = rand_addr(); req1_addr = rand_addr();
      req0_data = {$urandom, $urandom}; req1_data = {$urandom, $urandom};
      for (int i = 0; i < 16; i++) begin
         step();
         chk("burst_pat", r0_obs, ((i / 4) % 2 == 0) ? 1'b1 : 1'b0);
         if (g0) begin req0_addr = rand_addr(); req0_data = {$urandom, $urandom}; end
         if (g1) begin req1_addr = rand_addr(); req1_data = {$urandom, $urandom}; end
      end
      chk("burst_st0", stall0_count, 8'd8);
      chk("burst_st1", stall1_count, 8'd8);

      // freeze with both waiting
      do_reset();
      req0_valid = 1; req1_valid = 1; freeze = 1;
      for (int i = 0; i < 3; i++) step();
      chk("frz_st0", stall0_count, 8'd3);
      chk("frz_st1", stall1_count, 8'd3);
      freeze = 0;
      step();
      chk("frz_release", r0_obs, 1'b1);

      // reset right after accepting X5
      req1_valid = 0; req0_valid = 1; req0_addr = 5'd5; req0_data = 64'hAA;
      step();
      chk("x5_we", rf_reg_write, 1'b1);
      req0_valid = 0; reset = 1;
      #1;
      chk("x5_drop", rf_reg_write, 1'b0);
      step();
      reset = 0;
      chk("x5_we_after", rf_reg_write, 1'b0);
      chk("x5_addr_after", rf_write_register, '0);
      chk("x5_last_after", last_grant, 1'b1);

      // stall counter saturation
      do_reset();
      req0_valid = 1; req1_valid = 0; freeze = 1;
      for (int i = 0; i < 300; i++) step();
      chk("sat_st0", stall0_count, 8'd255);
      freeze = 0;

      // randomized traffic; pending writes keep their payload until accepted
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if (reset || !(req0_valid && !g0)) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req0_addr = rand_addr(); req0_data = {$urandom, $urandom};
         end
         if (reset || !(req1_valid && !g1)) begin
            req1_valid = ($urandom_range(0, 9) < 7);
            req1_addr = rand_addr(); req1_data = {$urandom, $urandom};
         end
         freeze = ($urandom_range(0, 9) == 0);
         reset  = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
